sr_pulse_controller: RTL and testbench



---
 rtl/sr_pulse_controller.sv | 170 +++++++++++++++++
 tb/tb_sr_pulse_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_controller.sv
`default_nettype none
// =============================================================================
// Module   : sr_pulse_controller
// Brief    : Synchronises and debounces set/reset buttons into mutually
//            exclusive, fixed-length S/R pulses for sr_flipflop.
// Options  : SR_CTRL_RESET_PRIORITY_EN - simultaneous requests issue a reset
// Revision : 1.0 - initial release
// =============================================================================
module sr_pulse_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_LEN       = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic SET_IN,
   input  logic RESET_IN,
   output logic S,
   output logic R,
   output logic BUSY,
   output logic CONFLICT,
   output logic Q_TRACK
);

   localparam logic [7:0] c_deb_last   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] c_pulse_last = 4'(PULSE_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE_S = 2'd1,
      ST_PULSE_R = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   logic [1:0] w_raw;
   logic [1:0] w_req;

   assign w_raw = {RESET_IN, SET_IN};

   // channel 0 = set button, channel 1 = reset button
   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic       r_sync1;
      logic       r_sync2;
      logic       r_level;
      logic       r_req;
      logic [7:0] r_cnt;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_req   <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_sync1 <= w_raw[gi];
            r_sync2 <= r_sync1;
            r_req   <= 1'b0;
            if (r_sync2 == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == c_deb_last) begin
               // accepted change; only a rising level becomes a request
               r_level <= r_sync2;
               r_cnt   <= '0;
               r_req   <= r_sync2;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end

      assign w_req[gi] = r_req;
   end

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_pcnt;
   logic [3:0] w_pcnt_nxt;
   logic       r_pend_s;
   logic       r_pend_r;
   logic       w_pend_s_nxt;
   logic       w_pend_r_nxt;
   logic       w_q_nxt;
   logic       w_conf_nxt;
   logic       w_eff_s;
   logic       w_eff_r;

   assign w_eff_s = w_req[0] | r_pend_s;
   assign w_eff_r = w_req[1] | r_pend_r;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= ST_IDLE;
         r_pcnt   <= '0;
         r_pend_s <= 1'b0;
         r_pend_r <= 1'b0;
         S        <= 1'b0;
         R        <= 1'b0;
         BUSY     <= 1'b0;
         CONFLICT <= 1'b0;
         Q_TRACK  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pcnt   <= w_pcnt_nxt;
         r_pend_s <= w_pend_s_nxt;
         r_pend_r <= w_pend_r_nxt;
         // outputs decoded from next state so they leave a flop directly
         S        <= (w_state_nxt == ST_PULSE_S);
         R        <= (w_state_nxt == ST_PULSE_R);
         BUSY     <= (w_state_nxt != ST_IDLE);
         CONFLICT <= w_conf_nxt;
         Q_TRACK  <= w_q_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pcnt_nxt   = r_pcnt;
      w_pend_s_nxt = r_pend_s;
      w_pend_r_nxt = r_pend_r;
      w_q_nxt      = Q_TRACK;
      w_conf_nxt   = 1'b0;

      if (r_state != ST_IDLE) begin
         w_pend_s_nxt = r_pend_s | w_req[0];
         w_pend_r_nxt = r_pend_r | w_req[1];
      end

      case (r_state)
         ST_IDLE: begin
            w_pend_s_nxt = 1'b0;
            w_pend_r_nxt = 1'b0;
            w_pcnt_nxt   = '0;
            if (w_eff_s && w_eff_r) begin
               w_conf_nxt = 1'b1;
`ifdef SR_CTRL_RESET_PRIORITY_EN
               w_state_nxt = ST_PULSE_R;
`endif
            end else if (w_eff_s) begin
               w_state_nxt = ST_PULSE_S;
            end else if (w_eff_r) begin
               w_state_nxt = ST_PULSE_R;
            end
         end
         ST_PULSE_S: begin
            if (r_pcnt == c_pulse_last) begin
               w_state_nxt = ST_GAP;
               w_q_nxt     = 1'b1;
            end else begin
               w_pcnt_nxt = r_pcnt + 4'd1;
            end
         end
         ST_PULSE_R: begin
            if (r_pcnt == c_pulse_last) begin
               w_state_nxt = ST_GAP;
               w_q_nxt     = 1'b0;
            end else begin
               w_pcnt_nxt = r_pcnt + 4'd1;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_controller.sv
`default_nettype none
// Bench for sr_pulse_controller: two instances (PULSE_LEN 1 and 3) share the
// button inputs and are checked every cycle against a schedule-based model.
module tb_sr_pulse_controller;

   localparam int DEB = 4;

   logic CLK      = 1'b0;
   logic RST_N    = 1'b0;
   logic SET_IN   = 1'b0;
   logic RESET_IN = 1'b0;
   logic [1:0] s_o, r_o, busy_o, conf_o, q_o;

   int n_cmp = 0;
   int n_bad = 0;

   sr_pulse_controller #(.DEBOUNCE_CYCLES(DEB), .PULSE_LEN(1)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .SET_IN(SET_IN), .RESET_IN(RESET_IN),
      .S(s_o[0]), .R(r_o[0]), .BUSY(busy_o[0]), .CONFLICT(conf_o[0]),
      .Q_TRACK(q_o[0]));

   sr_pulse_controller #(.DEBOUNCE_CYCLES(DEB), .PULSE_LEN(3)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .SET_IN(SET_IN), .RESET_IN(RESET_IN),
      .S(s_o[1]), .R(r_o[1]), .BUSY(busy_o[1]), .CONFLICT(conf_o[1]),
      .Q_TRACK(q_o[1]));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Button side: a level is accepted after DEB consecutive differing samples,
   // seen two edges late. Command side: a countdown of remaining busy cycles.
   int   plen[2] = '{1, 3};
   bit   smp1[2], smp2[2], lvl[2], req[2];
   int   run[2];
   int   rem[2];
   bit   kind_r[2], m_q[2], m_conf[2], pend_s[2], pend_r[2];

   task automatic model_step();
      bit es, er, raw[2], synced;
      raw[0] = SET_IN;
      raw[1] = RESET_IN;
      if (!RST_N) begin
         for (int c = 0; c < 2; c++) begin
            smp1[c] = 0; smp2[c] = 0; lvl[c] = 0; req[c] = 0; run[c] = 0;
            rem[c] = 0; kind_r[c] = 0; m_q[c] = 0; m_conf[c] = 0;
            pend_s[c] = 0; pend_r[c] = 0;
         end
         return;
      end
      for (int d = 0; d < 2; d++) begin
         m_conf[d] = 0;
         if (rem[d] == 0) begin
            es = req[0] | pend_s[d];
            er = req[1] | pend_r[d];
            pend_s[d] = 0;
            pend_r[d] = 0;
            if (es && er) begin
               m_conf[d] = 1;
`ifdef SR_CTRL_RESET_PRIORITY_EN
               rem[d] = plen[d] + 1; kind_r[d] = 1;
`endif
            end else if (es) begin
               rem[d] = plen[d] + 1; kind_r[d] = 0;
            end else if (er) begin
               rem[d] = plen[d] + 1; kind_r[d] = 1;
            end
         end else begin
            pend_s[d] = pend_s[d] | req[0];
            pend_r[d] = pend_r[d] | req[1];
            rem[d]--;
            if (rem[d] == 1) m_q[d] = !kind_r[d];
         end
      end
      for (int c = 0; c < 2; c++) begin
         synced = smp2[c];
         smp2[c] = smp1[c];
         smp1[c] = raw[c];
         req[c] = 0;
         if (synced != lvl[c]) begin
            run[c]++;
            if (run[c] == DEB) begin
               lvl[c] = synced; run[c] = 0; req[c] = synced;
            end
         end else begin
            run[c] = 0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         for (int d = 0; d < 2; d++) begin
            bit es, er, eb, ec, eq;
            if (!RST_N) begin
               es = 0; er = 0; eb = 0; ec = 0; eq = 0;
            end else begin
               es = (rem[d] >= 2) && !kind_r[d];
               er = (rem[d] >= 2) && kind_r[d];
               eb = (rem[d] > 0);
               ec = m_conf[d];
               eq = m_q[d];
            end
            chk($sformatf("S[%0d]", d), s_o[d], es);
            chk($sformatf("R[%0d]", d), r_o[d], er);
            chk($sformatf("BUSY[%0d]", d), busy_o[d], eb);
            chk($sformatf("CONFLICT[%0d]", d), conf_o[d], ec);
            chk($sformatf("Q_TRACK[%0d]", d), q_o[d], eq);
            chk($sformatf("S_and_R[%0d]", d), s_o[d] & r_o[d], 1'b0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   int cs[2], cr[2], cb[2], cc[2], first_r[2], first_c;

   task automatic clr_counts();
      for (int d = 0; d < 2; d++) begin
         cs[d] = 0; cr[d] = 0; cb[d] = 0; cc[d] = 0; first_r[d] = 0;
      end
      first_c = 0;
   endtask

   task automatic observe(input int i);
      for (int d = 0; d < 2; d++) begin
         cs[d] += int'(s_o[d]);
         cr[d] += int'(r_o[d]);
         cb[d] += int'(busy_o[d]);
         cc[d] += int'(conf_o[d]);
         if (r_o[d] && first_r[d] == 0) first_r[d] = i;
      end
      if (conf_o[0] && first_c == 0) first_c = i;
   endtask

   initial begin
      // reset state
      tick(3);
      for (int d = 0; d < 2; d++) begin
         chk("reset_S", s_o[d], 1'b0);
         chk("reset_BUSY", busy_o[d], 1'b0);
         chk("reset_Q", q_o[d], 1'b0);
      end
      RST_N = 1'b1;
      tick(3);

      // 1: set held, S after edge k+6 where k is the first sampling edge
      SET_IN = 1'b1;
      tick(6);
      chk("set_S_not_yet", s_o[0], 1'b0);
      tick(1);
      chk("set_S_rise_a", s_o[0], 1'b1);
      chk("set_S_rise_b", s_o[1], 1'b1);
      chk("set_R_low", r_o[0], 1'b0);
      chk("set_BUSY", busy_o[0], 1'b1);
      tick(1);
      chk("set_S_drop_a", s_o[0], 1'b0);
      chk("set_Q_a", q_o[0], 1'b1);
      chk("set_BUSY_gap", busy_o[0], 1'b1);
      tick(1);
      chk("set_BUSY_idle", busy_o[0], 1'b0);
      tick(10);
      chk("set_Q_b", q_o[1], 1'b1);

      // 6: releasing set gives no command
      SET_IN = 1'b0;
      clr_counts();
      for (int i = 1; i <= 12; i++) begin tick(1); observe(i); end
      chk_int("release_busy", cb[0], 0);
      chk("release_Q", q_o[0], 1'b1);

      // 2: short glitch rejected, long press accepted
      RESET_IN = 1'b1;
      tick(3);
      RESET_IN = 1'b0;
      clr_counts();
      for (int i = 1; i <= 15; i++) begin tick(1); observe(i); end
      chk_int("glitch_R", cr[0] + cr[1], 0);
      chk("glitch_Q", q_o[0], 1'b1);
      RESET_IN = 1'b1;
      clr_counts();
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (i == 10) RESET_IN = 1'b0;
         observe(i);
      end
      chk_int("hold_R_a", cr[0], 1);
      chk_int("hold_R_b", cr[1], 3);
      chk("hold_Q_a", q_o[0], 1'b0);
      chk("hold_Q_b", q_o[1], 1'b0);

      // 3: simultaneous press
      SET_IN = 1'b1;
      RESET_IN = 1'b1;
      clr_counts();
      for (int i = 1; i <= 15; i++) begin tick(1); observe(i); end
      chk_int("simul_conf_cnt", cc[0], 1);
      chk_int("simul_conf_at", first_c, 7);
      chk_int("simul_S", cs[0], 0);
`ifdef SR_CTRL_RESET_PRIORITY_EN
      chk_int("simul_R", cr[0], 1);
`else
      chk_int("simul_R", cr[0], 0);
`endif
      SET_IN = 1'b0;
      RESET_IN = 1'b0;
      tick(20);

      // 4: reset request queued behind a running set pulse
      SET_IN = 1'b1;
      clr_counts();
      for (int i = 1; i <= 25; i++) begin
         tick(1);
         if (i == 1) RESET_IN = 1'b1;
         observe(i);
      end
      chk_int("pend_S_b", cs[1], 3);
      chk_int("pend_R_b", cr[1], 3);
      chk_int("pend_Rat_b", first_r[1], 12);
      chk_int("pend_Rat_a", first_r[0], 10);
      chk_int("pend_R_a", cr[0], 1);
      SET_IN = 1'b0;
      RESET_IN = 1'b0;
      tick(20);

      // 5: reset mid-pulse, no replay afterwards
      SET_IN = 1'b1;
      tick(7);
      chk("midrst_S_before_a", s_o[0], 1'b1);
      chk("midrst_S_before_b", s_o[1], 1'b1);
      #1 RST_N = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("midrst_S", s_o[d], 1'b0);
         chk("midrst_BUSY", busy_o[d], 1'b0);
         chk("midrst_Q", q_o[d], 1'b0);
      end
      SET_IN = 1'b0;
      tick(2);
      RST_N = 1'b1;
      clr_counts();
      for (int i = 1; i <= 15; i++) begin tick(1); observe(i); end
      chk_int("norepl_S", cs[0] + cs[1], 0);
      chk_int("norepl_BUSY", cb[0] + cb[1], 0);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
